// File: rtl/dct_quant_stage.sv
// dct_quant_stage
// Quantize-then-dequantize stage placed between dct and idct so the chain
// models JPEG-style coefficient loss. Each coefficient is quantized with the
// JPEG luminance table scaled by a per-block power-of-two step, then
// immediately reconstructed.
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous active-low reset
//   start      coefficient valid (one per cycle while high)
//   din        raw dct word; coefficient is the top 15 bits (signed)
//   qshift     step exponent, step = QTAB[idx] << qshift (latched at idx 0)
//   bypass     pass the coefficient through unquantized (latched at idx 0)
//   done       output valid, start delayed by three cycles
//   dout       reconstructed coefficient, sign-extended to BitWidth+1 bits
//   idx_out    coefficient index (row-major, 0 = DC) of dout
//   block_end  one-cycle pulse with done when idx_out is 63
//   nz_count   nonzero quantized levels in the block that just ended
module dct_quant_stage #(
  parameter int BitWidth = 31
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [BitWidth:0] din,
  input  logic [2:0]        qshift,
  input  logic              bypass,
  output logic              done,
  output logic [BitWidth:0] dout,
  output logic [5:0]        idx_out,
  output logic              block_end,
  output logic [6:0]        nz_count
);

  // JPEG luminance quantization table, row-major.
  localparam logic [6:0] QTAB [64] = '{
    7'd16, 7'd11, 7'd10, 7'd16, 7'd24,  7'd40,  7'd51,  7'd61,
    7'd12, 7'd12, 7'd14, 7'd19, 7'd26,  7'd58,  7'd60,  7'd55,
    7'd14, 7'd13, 7'd16, 7'd24, 7'd40,  7'd57,  7'd69,  7'd56,
    7'd14, 7'd17, 7'd22, 7'd29, 7'd51,  7'd87,  7'd80,  7'd62,
    7'd18, 7'd22, 7'd37, 7'd56, 7'd68,  7'd109, 7'd103, 7'd77,
    7'd24, 7'd35, 7'd55, 7'd64, 7'd81,  7'd104, 7'd113, 7'd92,
    7'd49, 7'd64, 7'd78, 7'd87, 7'd103, 7'd121, 7'd120, 7'd101,
    7'd72, 7'd92, 7'd95, 7'd98, 7'd112, 7'd100, 7'd103, 7'd99
  };

  // Reciprocal ROM round(65536/Q), built at elaboration so no divider exists
  // in hardware. Largest entry (Q=10) is 6554, which fits in 13 bits.
  function automatic logic [64*13-1:0] build_recip();
    logic [64*13-1:0] r;
    r = '0;
    for (int i = 0; i < 64; i++) begin
      r[i*13 +: 13] = 13'((131072 + int'(QTAB[i])) / (2 * int'(QTAB[i])));
    end
    return r;
  endfunction

  localparam logic [64*13-1:0] RECIP_ROM = build_recip();

  logic [14:0] coef;
  logic        unused_din_bits;
  assign coef            = din[BitWidth -: 15];
  assign unused_din_bits = ^din[BitWidth-15:0];

  // Input index and per-block settings
  logic [5:0] idx;
  logic [2:0] qs_lat;
  logic       byp_lat;
  logic [2:0] qs_eff;
  logic       byp_eff;

  // Coefficient 0 uses the live inputs; the rest of the block uses the latch.
  assign qs_eff  = (idx == 6'd0) ? qshift : qs_lat;
  assign byp_eff = (idx == 6'd0) ? bypass : byp_lat;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx     <= '0;
      qs_lat  <= '0;
      byp_lat <= 1'b0;
    end else if (start) begin
      idx <= idx + 6'd1;
      if (idx == 6'd0) begin
        qs_lat  <= qshift;
        byp_lat <= bypass;
      end
    end else begin
      idx <= '0;
    end
  end

  // S1: register coefficient in sign-magnitude form
  logic        s1_valid, s1_neg, s1_byp;
  logic [14:0] s1_coef, s1_mag;
  logic [5:0]  s1_idx;
  logic [2:0]  s1_qs;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid <= 1'b0;
      s1_neg   <= 1'b0;
      s1_byp   <= 1'b0;
      s1_coef  <= '0;
      s1_mag   <= '0;
      s1_idx   <= '0;
      s1_qs    <= '0;
    end else begin
      s1_valid <= start;
      if (start) begin
        s1_coef <= coef;
        s1_neg  <= coef[14];
        s1_mag  <= coef[14] ? (~coef + 15'd1) : coef;
        s1_idx  <= idx;
        s1_qs   <= qs_eff;
        s1_byp  <= byp_eff;
      end
    end
  end

  // S2: reciprocal multiply, round half away from zero, shift, saturate
  logic [12:0] recip;
  logic [31:0] prod, rnd, shifted;
  logic [9:0]  lvl;
  logic        nz;

  always_comb begin
    recip   = RECIP_ROM[int'(s1_idx)*13 +: 13];
    prod    = 32'(s1_mag) * 32'(recip);
    rnd     = prod + (32'd1 << (5'd15 + 5'(s1_qs)));
    shifted = rnd >> (5'd16 + 5'(s1_qs));
    lvl     = (shifted > 32'd1023) ? 10'd1023 : shifted[9:0];
    nz      = s1_byp ? (s1_coef != 15'd0) : (lvl != 10'd0);
  end

  logic        s2_valid, s2_neg, s2_byp, s2_nz;
  logic [9:0]  s2_lvl;
  logic [14:0] s2_coef;
  logic [5:0]  s2_idx;
  logic [2:0]  s2_qs;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s2_valid <= 1'b0;
      s2_neg   <= 1'b0;
      s2_byp   <= 1'b0;
      s2_nz    <= 1'b0;
      s2_lvl   <= '0;
      s2_coef  <= '0;
      s2_idx   <= '0;
      s2_qs    <= '0;
    end else begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_neg  <= s1_neg;
        s2_byp  <= s1_byp;
        s2_nz   <= nz;
        s2_lvl  <= lvl;
        s2_coef <= s1_coef;
        s2_idx  <= s1_idx;
        s2_qs   <= s1_qs;
      end
    end
  end

  // S3: step multiply, saturate, restore sign (a negative zero folds to 0)
  logic [23:0] rfull;
  logic [14:0] r15, qval, out15;

  always_comb begin
    rfull = (24'(s2_lvl) * 24'(QTAB[s2_idx])) << s2_qs;
    r15   = (rfull > 24'd16383) ? 15'h3FFF : rfull[14:0];
    qval  = s2_neg ? (~r15 + 15'd1) : r15;
    out15 = s2_byp ? s2_coef : qval;
  end

  // Output registers and block statistics. A gap in the valid stream clears
  // the running count so a truncated block never reports.
  logic [6:0] nz_acc;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      done      <= 1'b0;
      dout      <= '0;
      idx_out   <= '0;
      block_end <= 1'b0;
      nz_count  <= '0;
      nz_acc    <= '0;
    end else begin
      done <= s2_valid;
      if (s2_valid) begin
        dout    <= {{(BitWidth-14){out15[14]}}, out15};
        idx_out <= s2_idx;
        if (s2_idx == 6'd63) begin
          block_end <= 1'b1;
          nz_count  <= nz_acc + 7'(s2_nz);
          nz_acc    <= '0;
        end else begin
          block_end <= 1'b0;
          nz_acc    <= nz_acc + 7'(s2_nz);
        end
      end else begin
        block_end <= 1'b0;
        nz_acc    <= '0;
      end
    end
  end

endmodule

// File: tb/tb_dct_quant_stage.sv
// tb_dct_quant_stage
// Self-checking bench for dct_quant_stage. A behavioural reference model
// computes each reconstructed coefficient directly from the quantizer
// arithmetic and tracks block statistics; outputs are compared every cycle.
module tb_dct_quant_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [31:0] din = '0;
  logic [2:0]  qshift = '0;
  logic        bypass = 1'b0;
  logic        done, block_end;
  logic [31:0] dout;
  logic [5:0]  idx_out;
  logic [6:0]  nz_count;

  int checks = 0;
  int errors = 0;

  dct_quant_stage #(.BitWidth(31)) dut (
    .clk(clk), .reset(reset), .start(start), .din(din), .qshift(qshift),
    .bypass(bypass), .done(done), .dout(dout), .idx_out(idx_out),
    .block_end(block_end), .nz_count(nz_count)
  );

  always #5 clk = ~clk;

  int QT [64] = '{
    16, 11, 10, 16, 24, 40, 51, 61,   12, 12, 14, 19, 26, 58, 60, 55,
    14, 13, 16, 24, 40, 57, 69, 56,   14, 17, 22, 29, 51, 87, 80, 62,
    18, 22, 37, 56, 68, 109, 103, 77, 24, 35, 55, 64, 81, 104, 113, 92,
    49, 64, 78, 87, 103, 121, 120, 101, 72, 92, 95, 98, 112, 100, 103, 99
  };

  typedef struct {
    logic        d;
    logic [31:0] v;
    int          idx;
    logic        be;
    int          nz;
  } exp_t;

  exp_t        pipe [3];
  int          m_idx, m_acc, m_lq;
  logic        m_lb;
  logic        ex_done, ex_be;
  logic [31:0] ex_dout;
  int          ex_idx, ex_nz;
  logic [31:0] seen [8][64];
  int          obs_blk;
  int          be_cnt;
  int          be_nz [$];
  int          first_idx;

  int stq [$];
  int cq  [$];
  int qsq [$];
  int bq  [$];

  // Reference: quantize with round(65536/Q), round half away from zero,
  // saturate level to 1023, reconstruct, saturate to 16383, restore sign.
  function automatic longint ref_recon(input int c, input int i, input int qs,
                                       input logic byp, output logic nzo);
    longint q, m, recip, lv, r;
    q = QT[i];
    if (byp) begin
      nzo = (c != 0);
      return c;
    end
    m     = (c < 0) ? -c : c;
    recip = (131072 + q) / (2 * q);
    lv    = (m * recip + (longint'(1) << (15 + qs))) >> (16 + qs);
    if (lv > 1023) lv = 1023;
    nzo = (lv != 0);
    r   = (lv * q) << qs;
    if (r > 16383) r = 16383;
    return (c < 0) ? -r : r;
  endfunction

  function automatic int rnd_coef();
    int s;
    s = $urandom_range(0, 3);
    case (s)
      0:       return 0;
      1:       return int'($urandom_range(0, 100)) - 50;
      2:       return int'($urandom_range(0, 4000)) - 2000;
      default: return int'($urandom_range(0, 32767)) - 16384;
    endcase
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      pipe[k].d = 1'b0; pipe[k].v = '0; pipe[k].idx = 0;
      pipe[k].be = 1'b0; pipe[k].nz = 0;
    end
    ex_done = 1'b0; ex_be = 1'b0; ex_dout = '0; ex_idx = 0; ex_nz = 0;
    m_idx = 0; m_acc = 0; m_lq = 0; m_lb = 1'b0;
  endtask

  task automatic clear_queues();
    stq.delete(); cq.delete(); qsq.delete(); bq.delete();
    obs_blk = -1; be_cnt = 0; be_nz.delete(); first_idx = -1;
  endtask

  task automatic push(input int st, input int c, input int qs, input int b);
    stq.push_back(st); cq.push_back(c); qsq.push_back(qs); bq.push_back(b);
  endtask

  // Drives one cycle, advances the model and captures observations.
  task automatic cycle(input logic st, input int c, input int qs, input logic byp);
    exp_t   e;
    logic   nzb;
    longint r;
    e.d = 1'b0; e.v = '0; e.idx = 0; e.be = 1'b0; e.nz = 0;
    if (st) begin
      if (m_idx == 0) begin
        m_lq = qs;
        m_lb = byp;
      end
      r     = ref_recon(c, m_idx, m_lq, m_lb, nzb);
      e.d   = 1'b1;
      e.v   = 32'(r);
      e.idx = m_idx;
      if (nzb) m_acc++;
      if (m_idx == 63) begin
        e.be  = 1'b1;
        e.nz  = m_acc;
        m_acc = 0;
      end
      m_idx = (m_idx + 1) % 64;
    end else begin
      m_idx = 0;
      m_acc = 0;
    end
    start  = st;
    din    = {15'(c), 17'($urandom)};
    qshift = 3'(qs);
    bypass = byp;
    @(posedge clk);
    pipe[2] = pipe[1];
    pipe[1] = pipe[0];
    pipe[0] = e;
    @(negedge clk);
    ex_done = pipe[2].d;
    ex_be   = pipe[2].be;
    if (pipe[2].d) begin
      ex_dout = pipe[2].v;
      ex_idx  = pipe[2].idx;
    end
    if (pipe[2].be) ex_nz = pipe[2].nz;
    if (done === 1'b1) begin
      if (idx_out == 6'd0) obs_blk++;
      if (obs_blk >= 0 && obs_blk < 8) seen[obs_blk][idx_out] = dout;
      if (first_idx < 0) first_idx = int'(idx_out);
    end
    if (block_end === 1'b1) begin
      be_cnt++;
      be_nz.push_back(int'(nz_count));
    end
  endtask

  task automatic test_reset();
    clear_queues();
    model_reset();
    #1;
    checks++;
    if ({done, block_end, dout, idx_out, nz_count} !== 47'd0) begin
      errors++;
      $display("[TB] FAIL reset_initial: got done=%b be=%b dout=%h idx=%0d nz=%0d, need all zero",
               done, block_end, dout, idx_out, nz_count);
    end
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 70; k++) push(1, rnd_coef(), 1, 0);
    for (int k = 0; k < stq.size(); k++) begin
      cycle(stq[k][0], cq[k], qsq[k], bq[k][0]);
      checks++;
      if (done !== ex_done || block_end !== ex_be || dout !== ex_dout ||
          idx_out !== 6'(ex_idx) || nz_count !== 7'(ex_nz)) begin
        errors++;
        $display("[TB] FAIL reset_run k=%0d: got done=%b be=%b dout=%h idx=%0d nz=%0d, need done=%b be=%b dout=%h idx=%0d nz=%0d",
                 k, done, block_end, dout, idx_out, nz_count, ex_done, ex_be, ex_dout, ex_idx, ex_nz);
      end
    end
    // Assert reset between edges with start high and data in flight
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if ({done, block_end, dout, idx_out, nz_count} !== 47'd0) begin
      errors++;
      $display("[TB] FAIL reset_async: got done=%b be=%b dout=%h idx=%0d nz=%0d, need all zero",
               done, block_end, dout, idx_out, nz_count);
    end
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    clear_queues();
    for (int k = 0; k < 64; k++) push(1, rnd_coef(), 0, 0);
    for (int k = 0; k < 3; k++) push(0, 0, 0, 0);
    for (int k = 0; k < stq.size(); k++) begin
      cycle(stq[k][0], cq[k], qsq[k], bq[k][0]);
      checks++;
      if (done !== ex_done || block_end !== ex_be || dout !== ex_dout ||
          idx_out !== 6'(ex_idx) || nz_count !== 7'(ex_nz)) begin
        errors++;
        $display("[TB] FAIL reset_after k=%0d: got done=%b be=%b dout=%h idx=%0d nz=%0d, need done=%b be=%b dout=%h idx=%0d nz=%0d",
                 k, done, block_end, dout, idx_out, nz_count, ex_done, ex_be, ex_dout, ex_idx, ex_nz);
      end
    end
    checks++;
    if (first_idx !== 0) begin
      errors++;
      $display("[TB] FAIL reset_first_idx: got %0d, need 0", first_idx);
    end
  endtask

  task automatic test_bypass();
    clear_queues();
    push(1, -5, 3, 1);
    push(1, 0, 5, 0);
    push(1, 7000, 0, 0);
    for (int k = 3; k < 64; k++) push(1, rnd_coef(), $urandom_range(0, 7), $urandom_range(0, 1));
    for (int k = 0; k < 3; k++) push(0, 0, 0, 0);
    for (int k = 0; k < stq.size(); k++) begin
      cycle(stq[k][0], cq[k], qsq[k], bq[k][0]);
      checks++;
      if (done !== ex_done || block_end !== ex_be || dout !== ex_dout ||
          idx_out !== 6'(ex_idx) || nz_count !== 7'(ex_nz)) begin
        errors++;
        $display("[TB] FAIL bypass_run k=%0d: got done=%b be=%b dout=%h idx=%0d nz=%0d, need done=%b be=%b dout=%h idx=%0d nz=%0d",
                 k, done, block_end, dout, idx_out, nz_count, ex_done, ex_be, ex_dout, ex_idx, ex_nz);
      end
    end
    checks++;
    if (seen[0][0] !== 32'hFFFFFFFB || seen[0][1] !== 32'd0 || seen[0][2] !== 32'd7000) begin
      errors++;
      $display("[TB] FAIL bypass_values: got %h %h %h, need FFFFFFFB 00000000 00001B58",
               seen[0][0], seen[0][1], seen[0][2]);
    end
  endtask

  task automatic test_dc();
    clear_queues();
    push(1, 1000, 0, 0);
    for (int k = 1; k < 64; k++) push(1, rnd_coef(), 0, 0);
    push(1, -1000, 0, 0);
    for (int k = 1; k < 64; k++) push(1, rnd_coef(), 0, 0);
    push(1, 16383, 0, 0);
    for (int k = 1; k < 64; k++) push(1, rnd_coef(), 0, 0);
    for (int k = 0; k < 3; k++) push(0, 0, 0, 0);
    for (int k = 0; k < stq.size(); k++) begin
      cycle(stq[k][0], cq[k], qsq[k], bq[k][0]);
      checks++;
      if (done !== ex_done || block_end !== ex_be || dout !== ex_dout ||
          idx_out !== 6'(ex_idx) || nz_count !== 7'(ex_nz)) begin
        errors++;
        $display("[TB] FAIL dc_run k=%0d: got done=%b be=%b dout=%h idx=%0d nz=%0d, need done=%b be=%b dout=%h idx=%0d nz=%0d",
                 k, done, block_end, dout, idx_out, nz_count, ex_done, ex_be, ex_dout, ex_idx, ex_nz);
      end
    end
    checks++;
    if (seen[0][0] !== 32'd1008) begin
      errors++;
      $display("[TB] FAIL dc_pos: got %h, need %h", seen[0][0], 32'd1008);
    end
    checks++;
    if (seen[1][0] !== 32'hFFFFFC10) begin
      errors++;
      $display("[TB] FAIL dc_neg: got %h, need FFFFFC10", seen[1][0]);
    end
    checks++;
    if (seen[2][0] !== 32'd16368) begin
      errors++;
      $display("[TB] FAIL dc_saturate: got %h, need %h", seen[2][0], 32'd16368);
    end
  endtask

  task automatic test_qshift_latch();
    clear_queues();
    for (int k = 0; k < 64; k++) push(1, 1000, (k < 5) ? 2 : 0, 0);
    for (int k = 0; k < 63; k++) push(1, rnd_coef(), 7, 0);
    push(1, 6335, 7, 0);
    for (int k = 0; k < 63; k++) push(1, rnd_coef(), 7, 0);
    push(1, -6335, 0, 1);
    for (int k = 0; k < 3; k++) push(0, 0, 0, 0);
    for (int k = 0; k < stq.size(); k++) begin
      cycle(stq[k][0], cq[k], qsq[k], bq[k][0]);
      checks++;
      if (done !== ex_done || block_end !== ex_be || dout !== ex_dout ||
          idx_out !== 6'(ex_idx) || nz_count !== 7'(ex_nz)) begin
        errors++;
        $display("[TB] FAIL qshift_run k=%0d: got done=%b be=%b dout=%h idx=%0d nz=%0d, need done=%b be=%b dout=%h idx=%0d nz=%0d",
                 k, done, block_end, dout, idx_out, nz_count, ex_done, ex_be, ex_dout, ex_idx, ex_nz);
      end
    end
    checks++;
    if (seen[0][0] !== 32'd1024 || seen[0][5] !== 32'd960 || seen[0][63] !== 32'd1188) begin
      errors++;
      $display("[TB] FAIL qshift_latched: got %0d %0d %0d, need 1024 960 1188",
               seen[0][0], seen[0][5], seen[0][63]);
    end
    checks++;
    if (seen[1][63] !== 32'd0 || seen[2][63] !== 32'd0) begin
      errors++;
      $display("[TB] FAIL qshift_max_zero: got %h %h, need 0 0", seen[1][63], seen[2][63]);
    end
  endtask

  task automatic test_back_to_back();
    clear_queues();
    for (int k = 0; k < 64; k++) push(1, (k == 0 || k == 10 || k == 20) ? 1000 : 0, 0, 0);
    for (int k = 0; k < 64; k++) push(1, 1000, 0, 0);
    for (int k = 0; k < 3; k++) push(0, 0, 0, 0);
    for (int k = 0; k < 30; k++) push(1, 1000, 0, 0);
    for (int k = 0; k < 2; k++) push(0, 0, 0, 0);
    for (int k = 0; k < 64; k++) push(1, rnd_coef(), 1, 0);
    for (int k = 0; k < 3; k++) push(0, 0, 0, 0);
    for (int k = 0; k < stq.size(); k++) begin
      cycle(stq[k][0], cq[k], qsq[k], bq[k][0]);
      checks++;
      if (done !== ex_done || block_end !== ex_be || dout !== ex_dout ||
          idx_out !== 6'(ex_idx) || nz_count !== 7'(ex_nz)) begin
        errors++;
        $display("[TB] FAIL b2b_run k=%0d: got done=%b be=%b dout=%h idx=%0d nz=%0d, need done=%b be=%b dout=%h idx=%0d nz=%0d",
                 k, done, block_end, dout, idx_out, nz_count, ex_done, ex_be, ex_dout, ex_idx, ex_nz);
      end
      if (k == 130) begin
        checks++;
        if (be_cnt !== 2 || be_nz.size() != 2 || be_nz[0] !== 3 || be_nz[1] !== 64) begin
          errors++;
          $display("[TB] FAIL b2b_blocks: got %0d block_ends, need 2 with nz 3 then 64", be_cnt);
        end
      end
    end
    checks++;
    if (be_cnt !== 3) begin
      errors++;
      $display("[TB] FAIL truncate_block_end: got %0d block_ends total, need 3", be_cnt);
    end
  endtask

  task automatic test_random();
    int qs;
    int b;
    clear_queues();
    qs = 0;
    b  = 0;
    for (int k = 0; k < 400; k++) begin
      if (k % 64 == 0) begin
        qs = $urandom_range(0, 7);
        b  = ($urandom_range(0, 3) == 0) ? 1 : 0;
      end
      push(($urandom_range(0, 49) == 0) ? 0 : 1, rnd_coef(), qs, b);
    end
    for (int k = 0; k < 3; k++) push(0, 0, 0, 0);
    for (int k = 0; k < stq.size(); k++) begin
      cycle(stq[k][0], cq[k], qsq[k], bq[k][0]);
      checks++;
      if (done !== ex_done || block_end !== ex_be || dout !== ex_dout ||
          idx_out !== 6'(ex_idx) || nz_count !== 7'(ex_nz)) begin
        errors++;
        $display("[TB] FAIL random_run k=%0d: got done=%b be=%b dout=%h idx=%0d nz=%0d, need done=%b be=%b dout=%h idx=%0d nz=%0d",
                 k, done, block_end, dout, idx_out, nz_count, ex_done, ex_be, ex_dout, ex_idx, ex_nz);
      end
    end
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_dc();
    test_qshift_latch();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
